// File: rtl/sonar_scan_ctrl.sv
// sonar_scan_ctrl: fires each ultrasonic ranger in turn, times its echo pulse
// in clk cycles and hands the result to the sensor register file as a
// one-cycle indexed write.
// Optional build macro SONAR_SCAN_CTRL_GLITCH_FILTER_EN adds a 3-cycle
// stability filter behind the echo synchronizers (pulses < 3 cycles dropped).
module sonar_scan_ctrl #(
    parameter int NUM_SENSORS    = 7,
    parameter int IDX_W          = 3,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int GAP_CYCLES     = 50000,
    parameter int CNT_W          = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic [NUM_SENSORS-1:0] trig,
    output logic                   result_valid,
    output logic [IDX_W-1:0]       result_idx,
    output logic [31:0]            result_data,
    output logic                   busy
);

    // One shared timer covers the trigger, echo-timeout and gap intervals.
    localparam int TMR_MAX_A = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
    localparam int TMR_MAX   = (TMR_MAX_A > GAP_CYCLES) ? TMR_MAX_A : GAP_CYCLES;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] TRIG_LAST = TMR_W'(TRIG_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] PTR_LAST  = IDX_W'(NUM_SENSORS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_STORE, S_GAP
    } state_e;

    state_e                 state_q, state_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;

    logic [NUM_SENSORS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NUM_SENSORS-1:0] echo_f;
    logic [NUM_SENSORS-1:0] echo_prev_q, echo_prev_d;
    logic                   echo_cur, echo_rise, timeout_flag;

    logic [NUM_SENSORS-1:0] trig_q, trig_d;
    logic                   result_valid_q, result_valid_d;
    logic [IDX_W-1:0]       result_idx_q, result_idx_d;
    logic [31:0]            result_data_q, result_data_d;
    logic                   busy_q, busy_d;

    // Echo input path: two synchronizer stages plus a one-cycle history for edge detection.
    always_comb begin
        sync1_d     = echo;
        sync2_d     = sync1_q;
        echo_prev_d = echo_f;
    end

    // Synchronizer and echo history registers.
    // NOTE: sequential blocks use non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            echo_prev_q <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            echo_prev_q <= echo_prev_d;
        end
    end

`ifdef SONAR_SCAN_CTRL_GLITCH_FILTER_EN
    logic [NUM_SENSORS-1:0] hist1_q, hist1_d, hist2_q, hist2_d, filt_q, filt_d;

    // Filtered echo follows the synchronized value once it has held for 3 cycles.
    always_comb begin
        hist1_d = sync2_q;
        hist2_d = hist1_q;
        filt_d  = filt_q;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (sync2_q[i] == hist1_q[i] && hist1_q[i] == hist2_q[i]) begin
                filt_d[i] = sync2_q[i];
            end
        end
    end

    // Stability filter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist1_q <= '0;
            hist2_q <= '0;
            filt_q  <= '0;
        end else begin
            hist1_q <= hist1_d;
            hist2_q <= hist2_d;
            filt_q  <= filt_d;
        end
    end

    assign echo_f = filt_q;
`else
    assign echo_f = sync2_q;
`endif

    // Only the channel under the pointer is ever looked at.
    assign echo_cur  = echo_f[ptr_q];
    assign echo_rise = echo_f[ptr_q] & ~echo_prev_q[ptr_q];

    // State and datapath registers; reset discards any partial measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state and datapath update for the scan sequence.
    // NOTE: every _d starts from its held value so no branch of the case can infer a latch.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_TRIG;
                    tmr_d   = '0;
                end
            end
            S_TRIG: begin
                if (tmr_q == TRIG_LAST) begin
                    state_d = S_WAIT_RISE;
                    tmr_d   = '0;
                    cnt_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_WAIT_RISE: begin
                if (echo_rise) begin
                    state_d = S_MEASURE;
                    cnt_d   = CNT_W'(1);
                end else if (tmr_q == TMO_LAST) begin
                    state_d = S_STORE;
                    cnt_d   = CNT_MAX;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_MEASURE: begin
                // A counter already at full scale with echo still high is a saturated reading.
                if (!echo_cur || cnt_q == CNT_MAX) begin
                    state_d = S_STORE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STORE: begin
                state_d = S_GAP;
                tmr_d   = '0;
                ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
            end
            S_GAP: begin
                if (tmr_q == GAP_LAST) begin
                    state_d = enable ? S_TRIG : S_IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Timeout is flagged when STORE is entered from WAIT_RISE or from a still-high MEASURE.
    assign timeout_flag = (state_q == S_WAIT_RISE) || (state_q == S_MEASURE && echo_cur);

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        trig_d         = '0;
        result_valid_d = 1'b0;
        result_idx_d   = result_idx_q;
        result_data_d  = result_data_q;
        busy_d         = (state_d != S_IDLE);
        if (state_d == S_TRIG) begin
            trig_d[ptr_q] = 1'b1;
        end
        if (state_d == S_STORE) begin
            result_valid_d = 1'b1;
            result_idx_d   = ptr_q;
            result_data_d  = {timeout_flag, {(31 - CNT_W){1'b0}}, cnt_d};
        end
    end

    // Registered outputs so trig and the result strobe are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q         <= '0;
            result_valid_q <= 1'b0;
            result_idx_q   <= '0;
            result_data_q  <= '0;
            busy_q         <= 1'b0;
        end else begin
            trig_q         <= trig_d;
            result_valid_q <= result_valid_d;
            result_idx_q   <= result_idx_d;
            result_data_q  <= result_data_d;
            busy_q         <= busy_d;
        end
    end

    assign trig         = trig_q;
    assign result_valid = result_valid_q;
    assign result_idx   = result_idx_q;
    assign result_data  = result_data_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_sonar_scan_ctrl.sv
// Bench for sonar_scan_ctrl with small timing parameters. Each scan's echo
// pattern is turned into an expected (idx, data, cycle) entry by a model that
// reasons about pulses, not about controller states; a monitor compares every
// result strobe against it. Build with SONAR_SCAN_CTRL_GLITCH_FILTER_EN to
// exercise the filtered variant.
module tb_sonar_scan_ctrl;

    localparam int NS   = 3;
    localparam int IW   = 2;
    localparam int TRIG = 4;
    localparam int TMO  = 50;
    localparam int GAPC = 8;
    localparam int CW   = 8;

`ifdef SONAR_SCAN_CTRL_GLITCH_FILTER_EN
    localparam int DLY  = 5;   // raw echo edge to edge seen by the controller
    localparam int MINP = 3;   // shortest pulse that counts
`else
    localparam int DLY  = 2;
    localparam int MINP = 1;
`endif
    localparam logic [31:0] TMO_WORD = {1'b1, {(31 - CW){1'b0}}, {CW{1'b1}}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enable = 1'b0;
    logic [NS-1:0] echo = '0;
    logic [NS-1:0] trig;
    logic          result_valid;
    logic [IW-1:0] result_idx;
    logic [31:0]   result_data;
    logic          busy;

    sonar_scan_ctrl #(
        .NUM_SENSORS   (NS),
        .IDX_W         (IW),
        .TRIG_CYCLES   (TRIG),
        .TIMEOUT_CYCLES(TMO),
        .GAP_CYCLES    (GAPC),
        .CNT_W         (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .echo        (echo),
        .trig        (trig),
        .result_valid(result_valid),
        .result_idx  (result_idx),
        .result_data (result_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Cycle number; at the negedge inside cycle k, cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected results.
    typedef struct {
        int          idx;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t exp_q[$];
    exp_t e_mon;

    // Echo schedule per channel (absolute cycle windows) and a stuck-high hold.
    int sch_r1[NS];
    int sch_f1[NS];
    int sch_r2[NS];
    int sch_f2[NS];
    bit sch_hold[NS];

    initial begin
        for (int c = 0; c < NS; c++) begin
            sch_r1[c] = 0; sch_f1[c] = 0; sch_r2[c] = 0; sch_f2[c] = 0; sch_hold[c] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int c = 0; c < NS; c++) begin
                echo[c] = sch_hold[c] || (cyc >= sch_r1[c] && cyc < sch_f1[c])
                                      || (cyc >= sch_r2[c] && cyc < sch_f2[c]);
            end
        end
    end

    // Model: the first pulse of at least MINP cycles is the echo; no usable
    // pulse before the timeout window closes, or a width beyond the counter
    // range, gives the timeout word. Result lands one cycle after the
    // controller sees the echo end (or the window close / counter fill).
    function automatic void model_scan(input int tf, input bit pre_high,
                                       input int r1, input int l1, input int r2, input int l2,
                                       output logic [31:0] data, output int due);
        bit found;
        int rise;
        int len;
        found = 1'b0;
        rise  = 0;
        len   = 0;
        if (!pre_high) begin
            if (l1 >= MINP) begin
                found = 1'b1; rise = r1; len = l1;
            end else if (l2 >= MINP) begin
                found = 1'b1; rise = r2; len = l2;
            end
        end
        if (!found || rise + DLY >= tf + TMO) begin
            data = TMO_WORD;
            due  = tf + TMO;
        end else if (len >= (1 << CW)) begin
            data = TMO_WORD;
            due  = rise + DLY + (1 << CW);
        end else begin
            data = 32'(len);
            due  = rise + len + DLY + 1;
        end
    endfunction

    // Observed result strobe, kept for hand-computed pins.
    int          last_cyc = -1;
    logic [31:0] last_data = '0;
    logic [IW-1:0] last_idx = '0;

    // Per-cycle monitor: trigger sanity and result comparison against the model.
    always @(negedge clk) begin
        check("trig_onehot0", 32'($onehot0(trig)), 32'd1);
        if (trig !== '0) check("busy_with_trig", 32'(busy), 32'd1);
        if (result_valid === 1'b1) begin
            last_cyc  = cyc;
            last_data = result_data;
            last_idx  = result_idx;
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(result_valid), 32'd0);
            end else begin
                e_mon = exp_q.pop_front();
                check("result_idx", 32'(result_idx), 32'(e_mon.idx));
                check("result_data", result_data, e_mon.data);
                check("result_cycle", 32'(cyc), 32'(e_mon.due));
            end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
            check("result_missing", 32'(result_valid), 32'd1);
            void'(exp_q.pop_front());
        end
    end

    task automatic wait_rise(input int ch, output int tr);
        int n;
        n = 0;
        while (trig[ch] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("trig_start_seen", 32'(trig[ch]), 32'd1);
        tr = cyc;
    endtask

    task automatic wait_fall(input int ch, input int tr, output int tf);
        int n;
        n = 0;
        while (trig[ch] === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tf = cyc;
        check("trig_width", 32'(tf - tr), 32'(TRIG));
    endtask

    // One channel scan: wait for its trigger, schedule the echo relative to the
    // trigger fall, post the model's expectation and wait for it to come due.
    task automatic run_scan(input int ch, input bit pre_high,
                            input int d1, input int l1, input int g2, input int l2,
                            input int drop_at, output int tr, output int tf, output int st);
        exp_t e;
        int r1;
        int r2;
        last_cyc = -1;
        if (pre_high) sch_hold[ch] = 1'b1;
        wait_rise(ch, tr);
        wait_fall(ch, tr, tf);
        r1 = tf + d1;
        r2 = r1 + l1 + g2;
        sch_r1[ch] = (l1 > 0) ? r1 : 0;
        sch_f1[ch] = (l1 > 0) ? r1 + l1 : 0;
        sch_r2[ch] = (l2 > 0) ? r2 : 0;
        sch_f2[ch] = (l2 > 0) ? r2 + l2 : 0;
        e.idx = ch;
        model_scan(tf, pre_high, r1, l1, r2, l2, e.data, e.due);
        exp_q.push_back(e);
        while (cyc <= e.due + 1) begin
            if (drop_at >= 0 && cyc == tf + drop_at) enable = 1'b0;
            @(negedge clk);
        end
        sch_hold[ch] = 1'b0;
        st = last_cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int tr;
        int tf;
        int st;
        int st0;
        logic [NS-1:0] seen_trig;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_trig", 32'(trig), 32'd0);
        check("reset_valid", 32'(result_valid), 32'd0);
        check("reset_idx", 32'(result_idx), 32'd0);
        check("reset_data", result_data, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Reset while trig[0] is firing: everything drops at once.
        enable = 1'b1;
        wait_rise(0, tr);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_trig", 32'(trig), 32'd0);
        check("midreset_valid", 32'(result_valid), 32'd0);
        check("midreset_idx", 32'(result_idx), 32'd0);
        check("midreset_data", result_data, 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Nominal: echo 10 cycles after trig fall, 37 cycles wide; scanning restarts at ch 0.
        run_scan(0, 1'b0, 10, 37, 0, 0, -1, tr, tf, st);
`ifdef SONAR_SCAN_CTRL_GLITCH_FILTER_EN
        check("nominal_latency", 32'(st - (tf + 47)), 32'd6);
`else
        check("nominal_latency", 32'(st - (tf + 47)), 32'd3);
`endif
        check("nominal_data", last_data, 32'h0000_0025);
        check("nominal_idx", 32'(last_idx), 32'd0);
        st0 = st;

        // Timeout: no echo on ch 1; 8 gap cycles separate STORE from trig[1].
        run_scan(1, 1'b0, 0, 0, 0, 0, -1, tr, tf, st);
        check("gap_to_trig1", 32'(tr - st0), 32'd9);
        check("timeout_latency", 32'(st - tf), 32'd50);
        check("timeout_data", last_data, 32'h8000_00FF);
        check("timeout_idx", 32'(last_idx), 32'd1);

        // Stuck-high echo on ch 2: no edge, so a timeout result.
        run_scan(2, 1'b1, 0, 0, 0, 0, -1, tr, tf, st);
        check("stuck_data", last_data, 32'h8000_00FF);
        check("stuck_idx", 32'(last_idx), 32'd2);

        // 300-cycle pulse on ch 0 after the wrap: saturates.
        run_scan(0, 1'b0, 10, 300, 0, 0, -1, tr, tf, st);
        check("saturate_data", last_data, 32'h8000_00FF);
        check("wrap_idx", 32'(last_idx), 32'd0);

        // Ch 1 with enable dropped mid-measurement: still reports, then stops.
        run_scan(1, 1'b0, 10, 20, 0, 0, 17, tr, tf, st);
        check("stop_data", last_data, 32'h0000_0014);
        check("stop_idx", 32'(last_idx), 32'd1);
        while (cyc < st + 8) @(negedge clk);
        check("busy_last_gap", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_after_stop", 32'(busy), 32'd0);
        seen_trig = '0;
        repeat (60) begin
            @(negedge clk);
            seen_trig = seen_trig | trig;
        end
        check("no_trig_after_stop", 32'(seen_trig), 32'd0);
        check("idx_holds", 32'(result_idx), 32'd1);
        check("data_holds", result_data, 32'h0000_0014);

        // Glitch: 2-cycle pulse, 5 low cycles, then a 20-cycle pulse on ch 2.
        enable = 1'b1;
        run_scan(2, 1'b0, 10, 2, 5, 20, -1, tr, tf, st);
        enable = 1'b0;
`ifdef SONAR_SCAN_CTRL_GLITCH_FILTER_EN
        check("glitch_data", last_data, 32'h0000_0014);
`else
        check("glitch_data", last_data, 32'h0000_0002);
`endif
        check("glitch_idx", 32'(last_idx), 32'd2);

        repeat (30) @(negedge clk);
        check("results_outstanding", 32'(exp_q.size()), 32'd0);
        check("idle_at_end", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
